// File: rtl/spi_host_cmd_arb_if.sv
// rtl/spi_host_cmd_arb_if.sv - handshake and command bundle shared by requesters, the arbiter and the SPI host
//
// Parameters:
//   NumReq : number of requesters (2..8)
//   MaxCS  : number of chip selects; chip-select index width is max(1, clog2(MaxCS))
//
// Signals (arbiter view, modport slave):
//   req_valid_i / req_ready_o : per-requester command handshake
//   req_csid_i, req_len_i, req_dir_i, req_speed_i, req_csaat_i : per-requester command fields, packed
//   req_done_o                : per-requester segment-complete pulse
//   cmd_valid_o / cmd_ready_i : command handshake towards the SPI host
//   cmd_csid_o .. cmd_csaat_o : forwarded fields of the granted requester
//   seg_done_i                : SPI host pulse, issued segment finished on the wire
//   abort_i                   : software abort, releases any lock
//   busy_o, owner_o, lock_timeout_o : status
// The master modport is the mirror image, used by whatever drives the requesters and the host side.
interface spi_host_cmd_arb_if #(
  parameter int NumReq = 3,
  parameter int MaxCS  = 1
);
  localparam int CsIdW = (MaxCS > 1) ? $clog2(MaxCS) : 1;
  localparam int OwnW  = $clog2(NumReq);

  logic [NumReq-1:0]       req_valid_i;
  logic [NumReq-1:0]       req_ready_o;
  logic [NumReq*CsIdW-1:0] req_csid_i;
  logic [NumReq*9-1:0]     req_len_i;
  logic [NumReq*2-1:0]     req_dir_i;
  logic [NumReq*2-1:0]     req_speed_i;
  logic [NumReq-1:0]       req_csaat_i;
  logic [NumReq-1:0]       req_done_o;

  logic                    cmd_valid_o;
  logic                    cmd_ready_i;
  logic [CsIdW-1:0]        cmd_csid_o;
  logic [8:0]              cmd_len_o;
  logic [1:0]              cmd_dir_o;
  logic [1:0]              cmd_speed_o;
  logic                    cmd_csaat_o;
  logic                    seg_done_i;

  logic                    abort_i;
  logic                    busy_o;
  logic [OwnW-1:0]         owner_o;
  logic                    lock_timeout_o;

  modport slave (
    input  req_valid_i, req_csid_i, req_len_i, req_dir_i, req_speed_i, req_csaat_i,
    input  cmd_ready_i, seg_done_i, abort_i,
    output req_ready_o, req_done_o,
    output cmd_valid_o, cmd_csid_o, cmd_len_o, cmd_dir_o, cmd_speed_o, cmd_csaat_o,
    output busy_o, owner_o, lock_timeout_o
  );

  modport master (
    output req_valid_i, req_csid_i, req_len_i, req_dir_i, req_speed_i, req_csaat_i,
    output cmd_ready_i, seg_done_i, abort_i,
    input  req_ready_o, req_done_o,
    input  cmd_valid_o, cmd_csid_o, cmd_len_o, cmd_dir_o, cmd_speed_o, cmd_csaat_o,
    input  busy_o, owner_o, lock_timeout_o
  );
endinterface

// File: rtl/spi_host_cmd_arb.sv
// rtl/spi_host_cmd_arb.sv - round-robin arbiter sharing one SPI host command port between requesters
//
// Grants one requester at a time, forwards its command to the SPI host, waits for the segment
// to finish and, when the segment asked to keep chip-select asserted (csaat), keeps the port
// locked to that requester until it sends a final segment, software aborts, or (optionally)
// the lock times out.
//
// Ports:
//   clk_i : clock
//   rst_i : asynchronous active-high reset
//   bus   : spi_host_cmd_arb_if.slave (requester handshakes/fields, SPI host command, status)
//
// Optional feature macro: SPI_HOST_CMD_ARB_TIMEOUT_EN
//   defined   : a LOCKED state with the owner idle for TimeoutCycles cycles is force-released
//               and lock_timeout_o pulses for one cycle.
//   undefined : no timeout counter, lock_timeout_o is constant 0.
module spi_host_cmd_arb #(
  parameter int NumReq        = 3,
  parameter int MaxCS         = 1,
  parameter int TimeoutCycles = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  spi_host_cmd_arb_if.slave bus
);

  localparam int CsIdW = (MaxCS > 1) ? $clog2(MaxCS) : 1;
  localparam int OwnW  = $clog2(NumReq);

  if (NumReq < 2 || NumReq > 8 || TimeoutCycles < 1) begin : g_bad_param
    $error("spi_host_cmd_arb: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUSY,
    LOCKED
  } state_e;

  state_e            state_q;
  logic [OwnW-1:0]   rr_q;
  logic [OwnW-1:0]   owner_q;
  logic              csaat_q;
  logic              abort_q;
  logic              cmd_valid_q;
  logic              busy_q;

  logic              grant_found;
  logic [OwnW-1:0]   grant_idx;
  logic [OwnW-1:0]   nxt_rr;
  logic [NumReq-1:0] owner_oh;

  // First valid requester at or after rr_q, wrapping at NumReq.
  always_comb begin : p_arb
    int j;
    logic [OwnW-1:0] idx;
    grant_found = 1'b0;
    grant_idx   = rr_q;
    j           = 0;
    idx         = '0;
    for (int i = 0; i < NumReq; i++) begin
      j = int'(rr_q) + i;
      if (j >= NumReq) begin
        j = j - NumReq;
      end
      idx = OwnW'(j);
      if (!grant_found && bus.req_valid_i[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  // Round-robin pointer after a release: one past the releasing owner.
  assign nxt_rr   = (owner_q == OwnW'(NumReq - 1)) ? '0 : owner_q + 1'b1;
  assign owner_oh = {{(NumReq-1){1'b0}}, 1'b1} << owner_q;

`ifdef SPI_HOST_CMD_ARB_TIMEOUT_EN
  localparam int CntW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
  logic [CntW-1:0] cnt_q;
  logic            lock_timeout_q;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      owner_q     <= '0;
      csaat_q     <= 1'b0;
      abort_q     <= 1'b0;
      cmd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SPI_HOST_CMD_ARB_TIMEOUT_EN
      cnt_q          <= '0;
      lock_timeout_q <= 1'b0;
`endif
    end else begin
`ifdef SPI_HOST_CMD_ARB_TIMEOUT_EN
      lock_timeout_q <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          abort_q <= 1'b0;
          // An abort while idle only moves the pointer; arbitration resumes next cycle.
          if (bus.abort_i) begin
            rr_q <= nxt_rr;
          end else if (grant_found) begin
            owner_q     <= grant_idx;
            state_q     <= ISSUE;
            cmd_valid_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end

        ISSUE: begin
          // Abort cannot cancel an offered command; remember it for the end of the segment.
          if (bus.abort_i) begin
            abort_q <= 1'b1;
          end
          if (bus.cmd_ready_i) begin
            csaat_q     <= bus.req_csaat_i[owner_q];
            state_q     <= BUSY;
            cmd_valid_q <= 1'b0;
          end
        end

        BUSY: begin
          if (bus.seg_done_i) begin
            if (csaat_q && !abort_q && !bus.abort_i) begin
              state_q <= LOCKED;
            end else begin
              state_q <= IDLE;
              rr_q    <= nxt_rr;
              abort_q <= 1'b0;
              busy_q  <= 1'b0;
            end
          end else if (bus.abort_i) begin
            abort_q <= 1'b1;
          end
        end

        LOCKED: begin
          if (bus.abort_i) begin
            state_q <= IDLE;
            rr_q    <= nxt_rr;
            abort_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SPI_HOST_CMD_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end else if (bus.req_valid_i[owner_q]) begin
            // Owner continues its chained transaction; no re-arbitration.
            state_q     <= ISSUE;
            cmd_valid_q <= 1'b1;
`ifdef SPI_HOST_CMD_ARB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
          end else begin
`ifdef SPI_HOST_CMD_ARB_TIMEOUT_EN
            if (cnt_q == CntW'(TimeoutCycles - 1)) begin
              state_q        <= IDLE;
              rr_q           <= nxt_rr;
              abort_q        <= 1'b0;
              busy_q         <= 1'b0;
              cnt_q          <= '0;
              lock_timeout_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
`endif
          end
        end
      endcase
    end
  end

  assign bus.cmd_valid_o = cmd_valid_q;
  assign bus.busy_o      = busy_q;
  assign bus.owner_o     = owner_q;

  // Ready and fields follow the owner combinationally while a command is offered.
  assign bus.req_ready_o = (cmd_valid_q && bus.cmd_ready_i) ? owner_oh : '0;
  assign bus.req_done_o  = ((state_q == BUSY) && bus.seg_done_i) ? owner_oh : '0;

  assign bus.cmd_csid_o  = cmd_valid_q ? bus.req_csid_i[int'(owner_q)*CsIdW +: CsIdW] : '0;
  assign bus.cmd_len_o   = cmd_valid_q ? bus.req_len_i[int'(owner_q)*9 +: 9]          : '0;
  assign bus.cmd_dir_o   = cmd_valid_q ? bus.req_dir_i[int'(owner_q)*2 +: 2]          : '0;
  assign bus.cmd_speed_o = cmd_valid_q ? bus.req_speed_i[int'(owner_q)*2 +: 2]        : '0;
  assign bus.cmd_csaat_o = cmd_valid_q ? bus.req_csaat_i[owner_q]                     : 1'b0;

`ifdef SPI_HOST_CMD_ARB_TIMEOUT_EN
  assign bus.lock_timeout_o = lock_timeout_q;
`else
  assign bus.lock_timeout_o = 1'b0;
`endif

  // Requesters must hold valid until accepted.
  a_valid_held : assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == ISSUE) |-> bus.req_valid_i[owner_q]);

  // The host only reports completion of a segment it is actually running.
  a_seg_done_in_busy : assert property (@(posedge clk_i) disable iff (rst_i)
    bus.seg_done_i |-> (state_q == BUSY));

endmodule

// File: doc/spi_host_cmd_arb.md
Name: spi_host_cmd_arb

Overview:
- Round-robin arbiter that shares one SPI host command interface between NumReq requesters (e.g. boot loader, DMA, SW register path).
- Sits between the requesters and the SPI host command FIFO / sequencer.
- Holds a lock while a requester chains segments with CSAAT=1, so chip-select stays owned by one master across a multi-segment transaction.
- Releases the lock on the final segment (CSAAT=0), on abort, or on optional lock timeout.

Parameters:
- NumReq, 3, number of requesters (2..8).
- MaxCS, 1, number of chip selects; CsIdW = max(1, $clog2(MaxCS)).
- TimeoutCycles, 256, LOCKED idle cycles before forced release (used only with SPI_HOST_CMD_ARB_TIMEOUT_EN).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- req_valid_i  in  NumReq  per-requester command valid.
- req_ready_o  out  NumReq  per-requester command accepted.
- req_csid_i  in  NumReq*CsIdW  chip-select index, requester k at bits [k*CsIdW +: CsIdW].
- req_len_i  in  NumReq*9  segment length minus one, in bytes.
- req_dir_i  in  NumReq*2  00 dummy, 01 rx, 10 tx, 11 bidir.
- req_speed_i  in  NumReq*2  00 std, 01 dual, 10 quad.
- req_csaat_i  in  NumReq  keep CS asserted after this segment.
- req_done_o  out  NumReq  1-cycle pulse when that requester's segment completes.
- cmd_valid_o  out  1  command to SPI host valid.
- cmd_ready_i  in  1  SPI host accepts command.
- cmd_csid_o  out  CsIdW  forwarded field.
- cmd_len_o  out  9  forwarded field.
- cmd_dir_o  out  2  forwarded field.
- cmd_speed_o  out  2  forwarded field.
- cmd_csaat_o  out  1  forwarded field.
- seg_done_i  in  1  SPI host pulse: the issued segment has finished on the wire.
- abort_i  in  1  SW abort; forces release of any lock.
- busy_o  out  1  state != IDLE.
- owner_o  out  $clog2(NumReq)  current/last granted requester index.
- lock_timeout_o  out  1  1-cycle pulse on forced timeout release.

Behaviour:
- FSM states: IDLE, ISSUE, BUSY, LOCKED.
- Reset (asynchronous, rst_i=1): state=IDLE, rr_ptr=0, owner=0, counter=0. All outputs 0: cmd_valid_o, req_ready_o, req_done_o, busy_o, owner_o, lock_timeout_o, cmd_* fields.
- IDLE: if any req_valid_i, grant the first set bit searching from rr_ptr upward, wrapping at NumReq. Register owner; next state ISSUE. Grant-to-cmd_valid_o latency is 1 cycle.
- ISSUE:
  - cmd_valid_o=1; cmd_* fields are combinational pass-through of the owner's req_* slice.
  - req_ready_o[owner]=cmd_ready_i; all other req_ready_o bits are 0.
  - On cmd_valid_o & cmd_ready_i: latch csaat into csaat_q; next state BUSY.
  - Requesters hold valid and fields stable until ready; valid dropping in ISSUE is a protocol violation (assertion).
- BUSY: wait for seg_done_i, then pulse req_done_o[owner] in the same cycle.
  - csaat_q=1: next state LOCKED.
  - csaat_q=0: next state IDLE, rr_ptr=(owner+1) mod NumReq.
- LOCKED: only the owner may issue. If req_valid_i[owner]=1, next state ISSUE (no re-arbitration); other requesters stay stalled.
- abort_i:
  - In LOCKED or IDLE: state -> IDLE, rr_ptr=(owner+1) mod NumReq.
  - In ISSUE or BUSY: abort is recorded in abort_q. The in-flight segment completes normally, then the FSM goes to IDLE regardless of csaat_q.
  - abort_q clears on entering IDLE.
- seg_done_i outside BUSY: ignored (assertion flags it).
- seg_done_i and abort_i in the same cycle while in BUSY: done pulse is issued and the FSM goes to IDLE.
- Round-robin: rr_ptr advances only on release, never per segment. A single active requester is re-granted back-to-back, IDLE->ISSUE, with 1 idle cycle between.
- Reset mid-transaction: immediate return to IDLE; no done pulse is generated.

Optional Feature:
- Macro: SPI_HOST_CMD_ARB_TIMEOUT_EN.
- Defined:
  - A counter increments each cycle in LOCKED while req_valid_i[owner]=0, and clears on leaving LOCKED.
  - When count reaches TimeoutCycles-1: state -> IDLE, rr_ptr advances, lock_timeout_o pulses for 1 cycle.
- Undefined: no counter; lock_timeout_o tied 0; LOCKED persists until the owner issues or abort_i is asserted.

Test Plan:
- Req0 and req2 valid at the same time after reset, both csaat=0 → grant req0 first (cmd_valid_o at cycle+1), then req2 after seg_done_i; owner_o sequence 0,2.
- Req1 issues len=3 with csaat=1 while req0 is pending; seg_done_i arrives → req_done_o[1] pulse; state LOCKED with req0 stalled. Req1 then issues csaat=0 → req0 is granted next.
- cmd_ready_i held low for 5 cycles in ISSUE → cmd_valid_o stays high, fields stable, req_ready_o all 0 except owner mirroring ready.
- abort_i asserted in BUSY with csaat_q=1 → done pulse on seg_done_i, then IDLE, not LOCKED; rr_ptr advanced.
- With macro, TimeoutCycles=8: lock held with no owner valid → lock_timeout_o pulses 8 cycles after entering LOCKED; waiting requester granted next cycle. Without macro → no pulse after 100 cycles.
- rst_i asserted in BUSY → all outputs 0 asynchronously; after release, req2 alone is granted with owner_o=2.
